vid_prefetch: RTL and testbench
===============================

// Module: vid_prefetch
// PURPOSE
// - SDRAM-side video word prefetcher sitting directly upstream of the VID display controller.
// - Burst-reads the framebuffer into a show-ahead word FIFO.
// - Presents the FIFO head on viddata and pops one word per VID req pulse.
// - Restarts at the framebuffer base on each vsync rising edge.
// - Hides SDRAM burst latency from VID's single-cycle req/viddata sampling.
// PARAMETERS
// - ADDR_W       22        SDRAM word-address width
// - FRAME_BASE   22'h37FC0 word address of first displayed word (top line)
// - FRAME_WORDS  24576     words per frame (1024*768/32)
// - DEPTH        64        FIFO depth in words; power of 2, >= 2*BURST_LEN
// - BURST_LEN    8         words per SDRAM burst; power of 2; divides FRAME_WORDS
// PORTS
// - clk           in   1       CPU/SDRAM clock (same clock as VID clk)
// - rst_n         in   1       async active-low reset
// - ce            in   1       clock enable shared with VID; gates pop only
// - vsync         in   1       from VID, +ve polarity; rising edge = frame restart
// - vid_req       in   1       from VID req; pop when vid_req & ce
// - viddata       out  32      FIFO head; 32'h0 when FIFO empty
// - mem_rd_req    out  1       burst request; held until mem_rd_ack
// - mem_rd_addr   out  ADDR_W  burst start word address; stable while mem_rd_req=1
// - mem_rd_ack    in   1       controller accepted the request this cycle
// - mem_rd_valid  in   1       one data beat this cycle
// - mem_rd_data   in   32      beat data
// - underrun      out  1       sticky: pop attempted while FIFO empty
// - underrun_cnt  out  16      underrun event count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - FIFO empty; viddata=0; mem_rd_req=0; mem_rd_addr=FRAME_BASE.
//   - Word counter 0; state IDLE; underrun=0; underrun_cnt=0.
// - FSM IDLE:
//   - If words_fetched<FRAME_WORDS and (DEPTH-count-inflight)>=BURST_LEN, go to REQ.
// - FSM REQ:
//   - mem_rd_req=1.
//   - On mem_rd_ack: set inflight=BURST_LEN, go to DATA.
//   - Request is never withdrawn before ack.
// - FSM DATA:
//   - Each mem_rd_valid pushes mem_rd_data and decrements inflight.
//   - On the last beat: mem_rd_addr += BURST_LEN, words_fetched += BURST_LEN, go to IDLE.
// - FSM DISCARD:
//   - Beats are dropped, not pushed; go to IDLE when inflight reaches 0.
// - Frame restart on vsync rise:
//   - Detect with a 1-cycle registered compare.
//   - FIFO flushed (count=0).
//   - mem_rd_addr=FRAME_BASE; words_fetched=0.
//   - From DATA go to DISCARD (inflight retained); from REQ keep REQ with the new address.
//   - A beat arriving in the restart cycle is dropped.
// - Pop: vid_req&ce with count>0 pops the head.
//   - VID samples viddata in the same cycle as req, so the head is combinational from storage.
// - Push and pop in the same cycle: count unchanged, order preserved.
// - Pop while empty:
//   - No pointer change; viddata=0.
//   - underrun<=1, held until reset.
//   - A same-cycle push is still stored.
// - No overflow by construction: credits count inflight beats.
//   - A push while full is a design error; covered by an assertion in the bench.
// - Frame end: after FRAME_WORDS words are fetched, no further requests until the next vsync rise.
// - Arithmetic: mem_rd_addr is modulo 2^ADDR_W; count is log2(DEPTH)+1 bits; pointers wrap naturally.
// CONFIGURATION
// - Macro VID_PREFETCH_UNDERRUN_CNT_EN.
// - Defined:
//   - underrun_cnt increments (saturating at 16'hFFFF) on every pop-while-empty.
//   - Cleared only by reset.
// - Undefined: underrun_cnt tied to 16'h0; no counter logic. underrun flag present in both builds.
// TESTING
// - Reset, ack after 3 cycles, 8 beats 1..8:
//   - mem_rd_addr=22'h37FC0.
//   - viddata=1 after 1st beat; next request addr 22'h37FC8.
// - Steady ack/valid with no pops:
//   - Requests stop at count=64.
//   - After 8 pops exactly one new request issues; no push while full.
// - Pop in the same cycle as a push with count=1:
//   - count stays 1; viddata shows the pushed word next cycle.
// - vsync rises mid-burst after 3 of 8 beats:
//   - Remaining 5 beats dropped; FIFO empty.
//   - Next request addr=22'h37FC0.
// - vid_req with empty FIFO, 3 times:
//   - underrun=1; viddata=0.
//   - underrun_cnt=3 with VID_PREFETCH_UNDERRUN_CNT_EN, else 0.
// - Full frame: after 3072 bursts (24576 words) no request until vsync rises; then restart at base.

Source files
------------

// File: rtl/vid_prefetch.sv
// SDRAM-side video prefetcher: bursts the framebuffer into a show-ahead FIFO feeding VID.
// Define VID_PREFETCH_UNDERRUN_CNT_EN to build the saturating underrun event counter.
module vid_prefetch #(
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = 22'h37FC0,
  parameter int                FRAME_WORDS = 24576,
  parameter int                DEPTH       = 64,
  parameter int                BURST_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              vsync,
  input  logic              vid_req,
  output logic [31:0]       viddata,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(BURST_LEN + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DISCARD} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, space;
  logic [IW-1:0] inflight;
  logic [WW-1:0] words;
  logic          vsync_d, restart, push, pop, pop_empty, last_beat;

  assign restart   = vsync & ~vsync_d;
  assign push      = (state == DATA) & mem_rd_valid & ~restart;
  assign pop       = vid_req & ce & (count != '0);
  assign pop_empty = vid_req & ce & (count == '0);
  assign last_beat = mem_rd_valid & (inflight == IW'(1));
  // Free slots net of beats already promised by an accepted burst.
  assign space     = CW'(DEPTH) - count - CW'(inflight);

  // Head is read straight from storage: VID samples it in the same cycle as req.
  assign viddata = (count == '0) ? 32'h0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (restart) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= FRAME_BASE;
      words       <= '0;
      inflight    <= '0;
      vsync_d     <= 1'b0;
    end else begin
      vsync_d <= vsync;
      case (state)
        IDLE: if (!restart && words < WW'(FRAME_WORDS) && space >= CW'(BURST_LEN)) begin
          state      <= REQ;
          mem_rd_req <= 1'b1;
        end
        // An ack in the restart cycle accepted the old address, so its beats are dropped.
        REQ: if (mem_rd_ack) begin
          mem_rd_req <= 1'b0;
          inflight   <= IW'(BURST_LEN);
          state      <= restart ? DISCARD : DATA;
        end
        DATA: begin
          if (mem_rd_valid) inflight <= inflight - IW'(1);
          if (last_beat) begin
            state       <= IDLE;
            mem_rd_addr <= mem_rd_addr + ADDR_W'(BURST_LEN);
            words       <= words + WW'(BURST_LEN);
          end else if (restart) begin
            state <= DISCARD;
          end
        end
        DISCARD: if (mem_rd_valid) begin
          inflight <= inflight - IW'(1);
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (restart) begin
        mem_rd_addr <= FRAME_BASE;
        words       <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         underrun <= 1'b0;
    else if (pop_empty) underrun <= 1'b1;
  end

`ifdef VID_PREFETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underrun_cnt <= '0;
    else if (pop_empty && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vid_prefetch.sv
// Bench for vid_prefetch: reset/first-burst vector table, directed corner cases,
// and randomized traffic against a queue-based model of the word stream VID should see.
module tb_vid_prefetch;
  localparam logic [21:0] BASE = 22'h37FC0;
  localparam int FRAME_WORDS = 24576;
  localparam int DEPTH       = 64;
  localparam int BL          = 8;

  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0, vsync = 1'b0, vid_req = 1'b0;
  logic        mem_rd_ack = 1'b0, mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = 32'h0, viddata;
  logic        mem_rd_req, underrun;
  logic [21:0] mem_rd_addr;
  logic [15:0] underrun_cnt;

  vid_prefetch dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .vsync(vsync), .vid_req(vid_req),
    .viddata(viddata), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Framebuffer contents served by the fake controller; never zero for real addresses.
  function automatic logic [31:0] word(input logic [21:0] a);
    return {a[9:0], a};
  endfunction

  // Model: the queue holds exactly the words VID should see, in order.
  logic [31:0] q[$];
  logic [21:0] m_addr, beat_addr, last_ack_addr;
  int          m_words, beats_left, n_acks, wait_cnt, ack_dly;
  logic        m_und, live, vs_prev;
  logic [15:0] m_cnt;
  int          pop_pct, ce_pct, valid_pct, ack_min, ack_max, beat_budget, force_pop;

  task automatic knobs(input int p, input int c, input int v, input int amin, input int amax);
    pop_pct = p; ce_pct = c; valid_pct = v; ack_min = amin; ack_max = amax;
    ack_dly = amin; beat_budget = -1; force_pop = -1;
  endtask

  task automatic step();
    logic        rs, da, dv, pp;
    logic [31:0] dd;
    chk("viddata", viddata, (q.size() != 0) ? q[0] : 32'h0);
    chk("underrun", 32'(underrun), 32'(m_und));
`ifdef VID_PREFETCH_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`else
    chk("underrun_cnt", 32'(underrun_cnt), 32'h0);
`endif
    if (m_words >= FRAME_WORDS) chk("frame_end_no_req", 32'(mem_rd_req), 32'h0);
    if (beats_left > 0) chk("req_while_busy", 32'(mem_rd_req), 32'h0);

    if (force_pop >= 0) begin vid_req = force_pop[0]; ce = 1'b1; end
    else begin
      vid_req = ($urandom_range(99) < pop_pct);
      ce      = ($urandom_range(99) < ce_pct);
    end
    da = 1'b0; dv = 1'b0; dd = $urandom;
    if (mem_rd_req && beats_left == 0) begin
      if (wait_cnt >= ack_dly) begin
        da = 1'b1; wait_cnt = 0; n_acks++; last_ack_addr = mem_rd_addr;
        chk("ack_addr", 32'(mem_rd_addr), 32'(m_addr));
        ack_dly = $urandom_range(ack_max, ack_min);
      end else wait_cnt++;
    end else if (beats_left > 0 && beat_budget != 0 && $urandom_range(99) < valid_pct) begin
      dv = 1'b1;
      dd = word(beat_addr + 22'(BL - beats_left));
      if (beat_budget > 0) beat_budget--;
    end

    rs = vsync && !vs_prev;
    vs_prev = vsync;
    pp = vid_req && ce;
    if (pp) begin
      if (q.size() == 0) begin
        m_und = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end else void'(q.pop_front());
    end
    if (dv) begin
      if (live && !rs) begin
        q.push_back(dd);
        if (q.size() > DEPTH) chk("no_push_full", 32'(q.size()), 32'(DEPTH));
      end
      beats_left--;
      if (beats_left == 0 && live && !rs) begin m_addr += 22'(BL); m_words += BL; end
    end
    if (da) begin beats_left = BL; beat_addr = mem_rd_addr; live = !rs; end
    if (rs) begin q.delete(); m_addr = BASE; m_words = 0; live = 1'b0; end

    mem_rd_ack = da; mem_rd_valid = dv; mem_rd_data = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; vsync = 1'b0; vid_req = 1'b0; ce = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'h0;
    #1;
    chk("rst_viddata", viddata, 32'h0);
    chk("rst_req", 32'(mem_rd_req), 32'h0);
    chk("rst_addr", 32'(mem_rd_addr), 32'(BASE));
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_cnt", 32'(underrun_cnt), 32'h0);
    q.delete(); m_addr = BASE; m_words = 0; m_und = 1'b0; m_cnt = '0;
    beats_left = 0; live = 1'b0; vs_prev = 1'b0; wait_cnt = 0; n_acks = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack, valid, req, ce;
    logic [31:0] data;
    logic        exp_req;
    logic [21:0] exp_addr;
    logic [31:0] exp_vd;
    logic        exp_und;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic v, input logic r, input logic c,
                              input logic [31:0] d, input logic er, input logic [21:0] ea,
                              input logic [31:0] ev, input logic eu);
    vec_t t;
    t.ack = a; t.valid = v; t.req = r; t.ce = c; t.data = d;
    t.exp_req = er; t.exp_addr = ea; t.exp_vd = ev; t.exp_und = eu;
    return t;
  endfunction

  vec_t tbl[25];

  initial begin
    logic [21:0] b8;
    b8 = BASE + 22'd8;
    // Row = expected outputs at this cycle, then inputs applied for the next edge.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, BASE, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, BASE, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, BASE, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, BASE, 0, 0);
    for (int i = 0; i < 8; i++)
      tbl[4+i] = mk(0, 1, 0, 0, 32'(i + 1), 0, BASE, (i == 0) ? 32'h0 : 32'h1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, b8, 1, 0);
    for (int i = 0; i < 8; i++)
      tbl[13+i] = mk(0, 0, 1, 1, 0, 1, b8, 32'(i + 1), 0);
    tbl[21] = mk(0, 0, 1, 0, 0, 1, b8, 0, 0);
    tbl[22] = mk(0, 0, 0, 1, 0, 1, b8, 0, 0);
    tbl[23] = mk(0, 0, 1, 1, 0, 1, b8, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 1, b8, 0, 1);

    knobs(0, 100, 100, 0, 0);
    reset_dut();
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("tbl%0d_req", i), 32'(mem_rd_req), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_rd_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_viddata", i), viddata, tbl[i].exp_vd);
      chk($sformatf("tbl%0d_underrun", i), 32'(underrun), 32'(tbl[i].exp_und));
      mem_rd_ack = tbl[i].ack; mem_rd_valid = tbl[i].valid; mem_rd_data = tbl[i].data;
      vid_req = tbl[i].req; ce = tbl[i].ce;
      @(posedge clk);
      @(negedge clk);
    end

    // Push and pop in the same cycle with one word held.
    reset_dut();
    knobs(0, 100, 100, 0, 0); force_pop = 0; beat_budget = 1;
    for (int i = 0; i < 20 && q.size() != 1; i++) step();
    chk("pp_reach", 32'(q.size()), 32'd1);
    beat_budget = 1; force_pop = 1;
    step();
    chk("pp_head", viddata, word(BASE + 22'd1));
    force_pop = 0;
    step();
    chk("pp_kept", viddata, word(BASE + 22'd1));

    // vsync rises after 3 of 8 beats.
    reset_dut();
    knobs(0, 100, 100, 2, 2); force_pop = 0; beat_budget = 3;
    for (int i = 0; i < 40 && !(beats_left == 5 && beat_budget == 0); i++) step();
    chk("vs_reach", 32'(beats_left), 32'd5);
    vsync = 1'b1; beat_budget = -1; n_acks = 0;
    for (int i = 0; i < 40 && n_acks == 0; i++) step();
    chk("vs_flushed", viddata, 32'h0);
    chk("vs_restart_addr", 32'(last_ack_addr), 32'(BASE));
    vsync = 1'b0;
    repeat (20) step();

    // Three pops with an empty FIFO.
    reset_dut();
    knobs(0, 100, 100, 50, 50); beat_budget = 0; force_pop = 1;
    repeat (3) step();
    force_pop = 0;
    step();
    chk("ur_flag", 32'(underrun), 32'h1);
    chk("ur_viddata", viddata, 32'h0);
`ifdef VID_PREFETCH_UNDERRUN_CNT_EN
    chk("ur_cnt", 32'(underrun_cnt), 32'd3);
`else
    chk("ur_cnt", 32'(underrun_cnt), 32'd0);
`endif

    // Fill to DEPTH with no pops, then free exactly one burst.
    reset_dut();
    knobs(0, 100, 100, 0, 0); force_pop = 0;
    repeat (150) step();
    chk("fill_bursts", 32'(n_acks), 32'(DEPTH / BL));
    chk("fill_req", 32'(mem_rd_req), 32'h0);
    force_pop = 1;
    repeat (BL) step();
    force_pop = 0;
    repeat (40) step();
    chk("refill_bursts", 32'(n_acks), 32'(DEPTH / BL + 1));

    // Randomized traffic with occasional vsync toggles.
    reset_dut();
    for (int ph = 0; ph < 8; ph++) begin
      knobs(int'($urandom_range(100)), int'($urandom_range(100, 50)),
            int'($urandom_range(100, 20)), 0, int'($urandom_range(5)));
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(99) < 2) vsync = ~vsync;
        step();
      end
    end
    vsync = 1'b0;

    // Whole frame, then restart on vsync.
    reset_dut();
    knobs(100, 100, 100, 0, 0);
    for (int i = 0; i < 40000 && m_words < FRAME_WORDS; i++) step();
    chk("frame_words", 32'(m_words), 32'(FRAME_WORDS));
    chk("frame_bursts", 32'(n_acks), 32'(FRAME_WORDS / BL));
    repeat (50) step();
    chk("frame_quiet", 32'(n_acks), 32'(FRAME_WORDS / BL));
    vsync = 1'b1;
    for (int i = 0; i < 30 && n_acks == FRAME_WORDS / BL; i++) step();
    chk("frame_restart_acks", 32'(n_acks), 32'(FRAME_WORDS / BL + 1));
    chk("frame_restart_addr", 32'(last_ack_addr), 32'(BASE));
    vsync = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
